// File: rtl/stream_seq_checker_if.sv
// Purpose : valid/ready stream bundle between an upstream source and the
//           stream_seq_checker sink.
// Signals : s_valid - source has a beat on s_data
//           s_ready - sink can take a beat this cycle
//           s_data  - beat payload, DW bits
// Modports: master = source side, slave = sink side.
interface stream_seq_checker_if #(
  parameter int DW = 32
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/stream_seq_checker.sv
// Purpose : valid/ready stream sink for self-test datapaths. A start pulse
//           arms it to accept a programmed number of beats. It applies
//           backpressure from a selectable ready pattern and checks every
//           accepted beat against an incrementing sequence. It counts beats
//           and mismatches and records the first bad beat.
// Ports   : clk, reset (synchronous, active-high)
//           i_run / i_num_beats / i_start_val - start pulse plus its operands
//           s_if (slave)       - upstream valid/ready/data stream
//           o_busy, o_done     - RUN state flag, one-cycle DONE pulse
//           o_err, o_err_cnt   - sticky mismatch flag, saturating count
//           o_beat_cnt         - beats accepted since the last start
//           o_first_bad_idx/_data - index and payload of the first mismatch
module stream_seq_checker #(
  parameter int          DW         = 32,
  parameter int          CNT_W      = 32,
  parameter int          READY_MODE = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_run,
  input  logic [CNT_W-1:0]     i_num_beats,
  input  logic [DW-1:0]        i_start_val,
  stream_seq_checker_if.slave  s_if,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [CNT_W-1:0]     o_beat_cnt,
  output logic [CNT_W-1:0]     o_err_cnt,
  output logic [CNT_W-1:0]     o_first_bad_idx,
  output logic [DW-1:0]        o_first_bad_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [DW-1:0]     exp_q, exp_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  errcnt_q, errcnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  bad_idx_q, bad_idx_d;
  logic [DW-1:0]     bad_data_q, bad_data_d;
  logic              ready_q, ready_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              tog_q, tog_d;
  logic              rdy_pat;
  logic              hs;
  logic              start;
  logic              last_beat;

  // ready_q is only ever 1 in RUN; the state term keeps hs self-evidently safe.
  assign hs        = s_if.s_valid & ready_q & (state_q == RUN);
  assign start     = (state_q == IDLE) & i_run;
  assign last_beat = (beat_q == num_q - CNT_W'(1));

  // Next-state logic; i_run is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_run) state_d = (i_num_beats == '0) ? DONE : RUN;
      RUN:     if (hs && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready pattern generators. Mode 2 offers ~tog_q so the first RUN cycle is
  // a ready cycle. The LFSR free-runs so the pattern differs between runs.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    tog_d  = (state_d == RUN) ? ~tog_q : 1'b0;
    case (READY_MODE)
      0:       rdy_pat = 1'b1;
      1:       rdy_pat = lfsr_q[0];
      2:       rdy_pat = ~tog_q;
      default: rdy_pat = 1'b1;
    endcase
    ready_d = (state_d == RUN) ? rdy_pat : 1'b0;
  end

  // Beat checking and result capture. A start clears the results. The
  // expected value advances on every beat, even after a mismatch, so one
  // corrupted beat counts as one error rather than a loss of sync.
  always_comb begin
    num_d      = num_q;
    exp_d      = exp_q;
    beat_d     = beat_q;
    errcnt_d   = errcnt_q;
    err_d      = err_q;
    bad_idx_d  = bad_idx_q;
    bad_data_d = bad_data_q;
    if (start) begin
      num_d      = i_num_beats;
      exp_d      = i_start_val;
      beat_d     = '0;
      errcnt_d   = '0;
      err_d      = 1'b0;
      bad_idx_d  = '0;
      bad_data_d = '0;
    end
    if (hs) begin
      beat_d = beat_q + CNT_W'(1);
      exp_d  = exp_q + DW'(1);
      if (s_if.s_data != exp_q) begin
        err_d = 1'b1;
        if (errcnt_q != '1) errcnt_d = errcnt_q + CNT_W'(1);
        if (!err_q) begin
          bad_idx_d  = beat_q;
          bad_data_d = s_if.s_data;
        end
      end
    end
  end

  // State and datapath registers; reset drops any run in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      num_q      <= '0;
      exp_q      <= '0;
      beat_q     <= '0;
      errcnt_q   <= '0;
      err_q      <= 1'b0;
      bad_idx_q  <= '0;
      bad_data_q <= '0;
      ready_q    <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      tog_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      exp_q      <= exp_d;
      beat_q     <= beat_d;
      errcnt_q   <= errcnt_d;
      err_q      <= err_d;
      bad_idx_q  <= bad_idx_d;
      bad_data_q <= bad_data_d;
      ready_q    <= ready_d;
      lfsr_q     <= lfsr_d;
      tog_q      <= tog_d;
    end
  end

  assign s_if.s_ready     = ready_q;
  assign o_busy           = (state_q == RUN);
  assign o_done           = (state_q == DONE);
  assign o_err            = err_q;
  assign o_beat_cnt       = beat_q;
  assign o_err_cnt        = errcnt_q;
  assign o_first_bad_idx  = bad_idx_q;
  assign o_first_bad_data = bad_data_q;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Purpose : self-checking bench for stream_seq_checker. There are three
//           instances, one per ready mode (0, 1, 2). Each is fed by a
//           directed source that walks a table of beat values.
// Ports   : none (top-level bench).
module tb_stream_seq_checker;
  localparam int DW = 32;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic run0, run1, run2;
  logic [CW-1:0] numBeats;
  logic [DW-1:0] startVal;

  stream_seq_checker_if #(.DW(DW)) bus0 ();
  stream_seq_checker_if #(.DW(DW)) bus1 ();
  stream_seq_checker_if #(.DW(DW)) bus2 ();

  logic busy0, done0, err0, busy1, done1, err1, busy2, done2, err2;
  logic [CW-1:0] beat0, errCnt0, badIdx0, beat1, errCnt1, badIdx1, beat2, errCnt2, badIdx2;
  logic [DW-1:0] badData0, badData1, badData2;

  int compareCount = 0;
  int failCount = 0;
  logic [DW-1:0] stimData [0:127];
  int cyc, stl;

  stream_seq_checker #(.DW(DW), .CNT_W(CW), .READY_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .i_run(run0), .i_num_beats(numBeats), .i_start_val(startVal),
    .s_if(bus0), .o_busy(busy0), .o_done(done0), .o_err(err0), .o_beat_cnt(beat0),
    .o_err_cnt(errCnt0), .o_first_bad_idx(badIdx0), .o_first_bad_data(badData0));

  stream_seq_checker #(.DW(DW), .CNT_W(CW), .READY_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .i_run(run1), .i_num_beats(numBeats), .i_start_val(startVal),
    .s_if(bus1), .o_busy(busy1), .o_done(done1), .o_err(err1), .o_beat_cnt(beat1),
    .o_err_cnt(errCnt1), .o_first_bad_idx(badIdx1), .o_first_bad_data(badData1));

  stream_seq_checker #(.DW(DW), .CNT_W(CW), .READY_MODE(2)) dut2 (
    .clk(clk), .reset(reset), .i_run(run2), .i_num_beats(numBeats), .i_start_val(startVal),
    .s_if(bus2), .o_busy(busy2), .o_done(done2), .o_err(err2), .o_beat_cnt(beat2),
    .o_err_cnt(errCnt2), .o_first_bad_idx(badIdx2), .o_first_bad_data(badData2));

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse i_run on one instance for a single cycle, starting from a negedge.
  task automatic startRun(input int which, input logic [CW-1:0] n, input logic [DW-1:0] sv);
    numBeats = n;
    startVal = sv;
    case (which)
      0: run0 = 1'b1;
      1: run1 = 1'b1;
      default: run2 = 1'b1;
    endcase
    @(negedge clk);
    run0 = 1'b0;
    run1 = 1'b0;
    run2 = 1'b0;
  endtask

  // Present stimData[idx] at each negedge. The next beat is taken only after
  // the posedge saw valid and ready together. s_ready is a register, so its
  // value read at the negedge is the one the next posedge will use.
  task automatic applyStimulus(input int which, input int nBeats, input bit randValid,
                               input int budget, output int cycles, output int stalls);
    int idx;
    logic v, r;
    idx = 0;
    cycles = 0;
    stalls = 0;
    while (idx < nBeats && cycles < budget) begin
      v = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
      case (which)
        0: begin bus0.s_valid = v; bus0.s_data = stimData[idx]; r = bus0.s_ready; end
        1: begin bus1.s_valid = v; bus1.s_data = stimData[idx]; r = bus1.s_ready; end
        default: begin bus2.s_valid = v; bus2.s_data = stimData[idx]; r = bus2.s_ready; end
      endcase
      if (!r) stalls++;
      @(negedge clk);
      if (v && r) idx++;
      cycles++;
    end
    checkOutput("beatsDelivered", 64'(idx), 64'(nBeats));
    bus0.s_valid = 1'b0;
    bus1.s_valid = 1'b0;
    bus2.s_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    run0 = 1'b0; run1 = 1'b0; run2 = 1'b0;
    numBeats = '0; startVal = '0;
    bus0.s_valid = 1'b0; bus0.s_data = '0;
    bus1.s_valid = 1'b0; bus1.s_data = '0;
    bus2.s_valid = 1'b0; bus2.s_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 64'(busy0), 64'd0);
    checkOutput("rstDone", 64'(done0), 64'd0);
    checkOutput("rstReady", 64'(bus0.s_ready), 64'd0);
    checkOutput("rstErr", 64'(err0), 64'd0);
    checkOutput("rstBeat", 64'(beat0), 64'd0);
    checkOutput("rstErrCnt", 64'(errCnt0), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // T1: mode 0, 100 beats back to back.
    $display("[TB] T1 mode0 100 beats");
    for (int i = 0; i < 128; i++) stimData[i] = DW'(i);
    startRun(0, 100, 0);
    checkOutput("t1BusyFirst", 64'(busy0), 64'd1);
    checkOutput("t1ReadyFirst", 64'(bus0.s_ready), 64'd1);
    applyStimulus(0, 100, 1'b0, 300, cyc, stl);
    checkOutput("t1Cycles", 64'(cyc), 64'd100);
    checkOutput("t1Done", 64'(done0), 64'd1);
    checkOutput("t1Beat", 64'(beat0), 64'd100);
    checkOutput("t1Err", 64'(err0), 64'd0);
    checkOutput("t1ReadyAfter", 64'(bus0.s_ready), 64'd0);
    @(negedge clk);
    checkOutput("t1DoneOnce", 64'(done0), 64'd0);
    checkOutput("t1BeatHold", 64'(beat0), 64'd100);

    // T2: mode 1 with random valid; mode 2 alternating ready.
    $display("[TB] T2 random backpressure and alternating ready");
    startRun(1, 100, 0);
    applyStimulus(1, 100, 1'b1, 3000, cyc, stl);
    checkOutput("t2Done", 64'(done1), 64'd1);
    checkOutput("t2Beat", 64'(beat1), 64'd100);
    checkOutput("t2ErrCnt", 64'(errCnt1), 64'd0);
    checkOutput("t2Stalled", 64'(stl > 0), 64'd1);
    startRun(2, 6, 0);
    applyStimulus(2, 6, 1'b0, 50, cyc, stl);
    checkOutput("t2AltCycles", 64'(cyc), 64'd11);
    checkOutput("t2AltStalls", 64'(stl), 64'd5);
    checkOutput("t2AltBeat", 64'(beat2), 64'd6);
    checkOutput("t2AltDone", 64'(done2), 64'd1);
    @(negedge clk);

    // T3: two corrupted beats in a run of five.
    $display("[TB] T3 mismatch capture");
    stimData[0] = 32'd0; stimData[1] = 32'd1; stimData[2] = 32'd7;
    stimData[3] = 32'd3; stimData[4] = 32'd9;
    startRun(0, 5, 0);
    applyStimulus(0, 5, 1'b0, 50, cyc, stl);
    checkOutput("t3Err", 64'(err0), 64'd1);
    checkOutput("t3ErrCnt", 64'(errCnt0), 64'd2);
    checkOutput("t3BadIdx", 64'(badIdx0), 64'd2);
    checkOutput("t3BadData", 64'(badData0), 64'd7);
    checkOutput("t3Beat", 64'(beat0), 64'd5);
    @(negedge clk);

    // T4: expected value wraps through all-ones; a new start clears T3 results.
    $display("[TB] T4 wrap");
    stimData[0] = 32'hFFFFFFFE; stimData[1] = 32'hFFFFFFFF;
    stimData[2] = 32'h0;        stimData[3] = 32'h1;
    startRun(0, 4, 32'hFFFFFFFE);
    applyStimulus(0, 4, 1'b0, 50, cyc, stl);
    checkOutput("t4Err", 64'(err0), 64'd0);
    checkOutput("t4ErrCnt", 64'(errCnt0), 64'd0);
    checkOutput("t4BadIdx", 64'(badIdx0), 64'd0);
    checkOutput("t4BadData", 64'(badData0), 64'd0);
    checkOutput("t4Beat", 64'(beat0), 64'd4);
    repeat (3) @(negedge clk);
    checkOutput("t4HoldBeat", 64'(beat0), 64'd4);
    checkOutput("t4HoldDone", 64'(done0), 64'd0);

    // T5: zero-beat run, then an i_run during RUN must be ignored.
    $display("[TB] T5 zero beats and ignored restart");
    startRun(0, 0, 0);
    checkOutput("t5Done", 64'(done0), 64'd1);
    checkOutput("t5Busy", 64'(busy0), 64'd0);
    checkOutput("t5Ready", 64'(bus0.s_ready), 64'd0);
    @(negedge clk);
    checkOutput("t5DoneOnce", 64'(done0), 64'd0);
    checkOutput("t5ReadyIdle", 64'(bus0.s_ready), 64'd0);
    for (int i = 0; i < 128; i++) stimData[i] = DW'(i);
    startRun(0, 3, 0);
    numBeats = 50;
    startVal = 100;
    run0 = 1'b1;
    @(negedge clk);
    run0 = 1'b0;
    applyStimulus(0, 3, 1'b0, 50, cyc, stl);
    checkOutput("t5IgnDone", 64'(done0), 64'd1);
    checkOutput("t5IgnBeat", 64'(beat0), 64'd3);
    checkOutput("t5IgnErr", 64'(err0), 64'd0);
    @(negedge clk);

    // T6: reset in the middle of a run, then a clean rerun.
    $display("[TB] T6 reset mid-run");
    stimData[5] = 32'd999;
    startRun(0, 100, 0);
    applyStimulus(0, 40, 1'b0, 100, cyc, stl);
    checkOutput("t6MidBeat", 64'(beat0), 64'd40);
    checkOutput("t6MidErrCnt", 64'(errCnt0), 64'd1);
    checkOutput("t6MidBusy", 64'(busy0), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6RstBusy", 64'(busy0), 64'd0);
    checkOutput("t6RstReady", 64'(bus0.s_ready), 64'd0);
    checkOutput("t6RstBeat", 64'(beat0), 64'd0);
    checkOutput("t6RstErr", 64'(err0), 64'd0);
    checkOutput("t6RstErrCnt", 64'(errCnt0), 64'd0);
    checkOutput("t6RstBadIdx", 64'(badIdx0), 64'd0);
    checkOutput("t6RstBadData", 64'(badData0), 64'd0);
    reset = 1'b0;
    stimData[5] = 32'd5;
    @(negedge clk);
    startRun(0, 10, 0);
    applyStimulus(0, 10, 1'b0, 50, cyc, stl);
    checkOutput("t6RerunDone", 64'(done0), 64'd1);
    checkOutput("t6RerunBeat", 64'(beat0), 64'd10);
    checkOutput("t6RerunErr", 64'(err0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
